// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state encodings and
// elaboration-time sizing helpers.
package pll_reset_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  // Encodings as seen on state_o; the status register decodes these values.
  localparam logic [STATE_W-1:0] ST_PLL_RST   = S_PLL_RST;
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = S_WAIT_LOCK;
  localparam logic [STATE_W-1:0] ST_STABLE    = S_STABLE;
  localparam logic [STATE_W-1:0] ST_RUN       = S_RUN;
  localparam logic [STATE_W-1:0] ST_FAULT     = S_FAULT;

  function automatic int clog2_f(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  function automatic int max3_f(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-side handshake plus system-side status of the reset sequencer.
interface pll_reset_sequencer_if
  import pll_reset_sequencer_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic               pll_locked_i;
  logic               req_reset_i;
  logic               pll_rst_o;
  logic               sys_rst_o;
  logic               ready_o;
  logic               fault_o;
  logic [STATE_W-1:0] state_o;
  logic [3:0]         retry_count_o;
  logic [CNT_W-1:0]   relock_count_o;

  modport master (
    input  pll_locked_i,
    input  req_reset_i,
    output pll_rst_o,
    output sys_rst_o,
    output ready_o,
    output fault_o,
    output state_o,
    output retry_count_o,
    output relock_count_o
  );

  modport slave (
    output pll_locked_i,
    output req_reset_i,
    input  pll_rst_o,
    input  sys_rst_o,
    input  ready_o,
    input  fault_o,
    input  state_o,
    input  retry_count_o,
    input  relock_count_o
  );

endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for slow status bits entering the refclk domain;
// both stages reset to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives PLL reset, qualifies lock and releases the downstream system reset
// once lock is stable; retries on timeout and latches a fault after repeats.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   PLL_RST   | PLL held in reset for RST_CYCLES
//   WAIT_LOCK | PLL running, waiting for synced lock (bounded by timeout)
//   STABLE    | lock seen, must hold LOCK_STABLE cycles before release
//   RUN       | system out of reset, loss of lock filtered
//   FAULT     | retries exhausted, both resets held until req_reset_i
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int LOCK_STABLE   = 1024,
  parameter int UNLOCK_FILTER = 4,
  parameter int MAX_RETRIES   = 8,
  parameter int CNT_W         = 8
) (
  input  logic                   refclk,
  input  logic                   rst_n,
  pll_reset_sequencer_if.master  bus
);

  localparam int TMR_W = clog2_f(max3_f(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE) + 1);
  localparam int UNL_W = clog2_f(UNLOCK_FILTER + 1);

  logic [STATE_W-1:0] state, state_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [3:0]         retry_cnt, retry_nxt, retry_inc;
  logic [CNT_W-1:0]   relock_cnt, relock_nxt;
  logic [UNL_W-1:0]   unlock_cnt, unlock_nxt;
  logic               locked_s;
  logic               pll_rst_q, sys_rst_q, ready_q, fault_q;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (bus.pll_locked_i),
    .q     (locked_s)
  );

  always_comb begin
    state_nxt  = state;
    retry_nxt  = retry_cnt;
    relock_nxt = relock_cnt;
    unlock_nxt = '0;
    retry_inc  = retry_cnt + 4'd1;

    case (state)
      ST_PLL_RST: begin
        if (timer == TMR_W'(RST_CYCLES - 1)) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = ST_STABLE;
        end else if (timer == TMR_W'(LOCK_TIMEOUT - 1)) begin
          retry_nxt = retry_inc;
          state_nxt = (retry_inc == 4'(MAX_RETRIES)) ? ST_FAULT : ST_PLL_RST;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_nxt = ST_WAIT_LOCK;
        end else if (timer == TMR_W'(LOCK_STABLE - 1)) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Only a run of UNLOCK_FILTER synced-low cycles counts as lost lock.
        if (!locked_s) begin
          if (unlock_cnt == UNL_W'(UNLOCK_FILTER - 1)) begin
            state_nxt = ST_PLL_RST;
            if (relock_cnt != '1) relock_nxt = relock_cnt + CNT_W'(1);
          end else begin
            unlock_nxt = unlock_cnt + UNL_W'(1);
          end
        end
      end
      ST_FAULT: begin
        state_nxt = ST_FAULT;
      end
      default: begin
        state_nxt = ST_PLL_RST;
      end
    endcase

    if (bus.req_reset_i) begin
      state_nxt  = ST_PLL_RST;
      retry_nxt  = '0;
      unlock_nxt = '0;
    end

    // Timer only advances in the timed states; it is zero on entry to any state.
    if ((state_nxt != state) || bus.req_reset_i) begin
      timer_nxt = '0;
    end else if ((state == ST_PLL_RST) || (state == ST_WAIT_LOCK) || (state == ST_STABLE)) begin
      timer_nxt = timer + TMR_W'(1);
    end else begin
      timer_nxt = timer;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_PLL_RST;
      timer      <= '0;
      retry_cnt  <= '0;
      relock_cnt <= '0;
      unlock_cnt <= '0;
      pll_rst_q  <= 1'b1;
      sys_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      retry_cnt  <= retry_nxt;
      relock_cnt <= relock_nxt;
      unlock_cnt <= unlock_nxt;
      pll_rst_q  <= (state_nxt == ST_PLL_RST) || (state_nxt == ST_FAULT);
      sys_rst_q  <= (state_nxt != ST_RUN);
      ready_q    <= (state_nxt == ST_RUN);
      fault_q    <= (state_nxt == ST_FAULT);
    end
  end

  assign bus.pll_rst_o      = pll_rst_q;
  assign bus.sys_rst_o      = sys_rst_q;
  assign bus.ready_o        = ready_q;
  assign bus.fault_o        = fault_q;
  assign bus.state_o        = state;
  assign bus.retry_count_o  = retry_cnt;
  assign bus.relock_count_o = relock_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: a cycle table for bring-up and the
// RUN unlock filter, then hand sequences for glitch, timeout, fault and reset.
module tb_pll_reset_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int LOCK_STABLE   = 8;
  localparam int UNLOCK_FILTER = 3;
  localparam int MAX_RETRIES   = 2;
  localparam int CNT_W         = 8;

  logic refclk = 1'b0;
  logic rst_n;

  always #5 refclk = ~refclk;

  pll_reset_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pll_reset_sequencer #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .LOCK_STABLE   (LOCK_STABLE),
    .UNLOCK_FILTER (UNLOCK_FILTER),
    .MAX_RETRIES   (MAX_RETRIES),
    .CNT_W         (CNT_W)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         adv;
    logic       locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [2:0] state;
    logic [3:0] retry;
    logic [7:0] relock;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(int adv, logic lk, logic pr, logic sr, logic rd, logic ft,
                              logic [2:0] st, logic [3:0] rt, logic [7:0] rl);
    vec_t v;
    v.adv = adv; v.locked = lk; v.pll_rst = pr; v.sys_rst = sr; v.ready = rd;
    v.fault = ft; v.state = st; v.retry = rt; v.relock = rl;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic pr, input logic sr, input logic rd,
                            input logic ft, input logic [2:0] st, input logic [3:0] rt,
                            input logic [7:0] rl);
    check({tag, ".pll_rst"}, 32'(bus.pll_rst_o), 32'(pr));
    check({tag, ".sys_rst"}, 32'(bus.sys_rst_o), 32'(sr));
    check({tag, ".ready"},   32'(bus.ready_o),   32'(rd));
    check({tag, ".fault"},   32'(bus.fault_o),   32'(ft));
    check({tag, ".state"},   32'(bus.state_o),   32'(st));
    check({tag, ".retry"},   32'(bus.retry_count_o),  32'(rt));
    check({tag, ".relock"},  32'(bus.relock_count_o), 32'(rl));
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Clean bring-up (edges counted from reset release), then RUN unlock filter.
    tbl[0]  = mk(3, 1'b0, 1, 1, 0, 0, 3'd0, 4'd0, 8'd0);
    tbl[1]  = mk(1, 1'b0, 0, 1, 0, 0, 3'd1, 4'd0, 8'd0);
    tbl[2]  = mk(9, 1'b0, 0, 1, 0, 0, 3'd1, 4'd0, 8'd0);
    tbl[3]  = mk(2, 1'b1, 0, 1, 0, 0, 3'd1, 4'd0, 8'd0);
    tbl[4]  = mk(1, 1'b1, 0, 1, 0, 0, 3'd2, 4'd0, 8'd0);
    tbl[5]  = mk(7, 1'b1, 0, 1, 0, 0, 3'd2, 4'd0, 8'd0);
    tbl[6]  = mk(1, 1'b1, 0, 0, 1, 0, 3'd3, 4'd0, 8'd0);
    tbl[7]  = mk(5, 1'b1, 0, 0, 1, 0, 3'd3, 4'd0, 8'd0);
    tbl[8]  = mk(2, 1'b0, 0, 0, 1, 0, 3'd3, 4'd0, 8'd0);
    tbl[9]  = mk(5, 1'b1, 0, 0, 1, 0, 3'd3, 4'd0, 8'd0);
    tbl[10] = mk(3, 1'b0, 0, 0, 1, 0, 3'd3, 4'd0, 8'd0);
    tbl[11] = mk(1, 1'b1, 0, 0, 1, 0, 3'd3, 4'd0, 8'd0);
    tbl[12] = mk(1, 1'b1, 1, 1, 0, 0, 3'd0, 4'd0, 8'd1);
    tbl[13] = mk(4, 1'b1, 0, 1, 0, 0, 3'd1, 4'd0, 8'd1);
    tbl[14] = mk(1, 1'b1, 0, 1, 0, 0, 3'd2, 4'd0, 8'd1);
    tbl[15] = mk(7, 1'b1, 0, 1, 0, 0, 3'd2, 4'd0, 8'd1);
    tbl[16] = mk(1, 1'b1, 0, 0, 1, 0, 3'd3, 4'd0, 8'd1);

    rst_n            = 1'b0;
    bus.pll_locked_i = 1'b0;
    bus.req_reset_i  = 1'b0;
    tick(3);
    check_outs("reset", 1, 1, 0, 0, 3'd0, 4'd0, 8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      bus.pll_locked_i = tbl[i].locked;
      tick(tbl[i].adv);
      check_outs($sformatf("row%0d", i), tbl[i].pll_rst, tbl[i].sys_rst, tbl[i].ready,
                 tbl[i].fault, tbl[i].state, tbl[i].retry, tbl[i].relock);
    end

    // Software re-init from RUN, then a one-cycle lock glitch while in STABLE.
    bus.req_reset_i = 1'b1;
    tick(1);
    bus.req_reset_i = 1'b0;
    check_outs("req_run", 1, 1, 0, 0, 3'd0, 4'd0, 8'd1);
    tick(4);
    check_outs("req_wait", 0, 1, 0, 0, 3'd1, 4'd0, 8'd1);
    tick(5);
    check_outs("stable_pre_glitch", 0, 1, 0, 0, 3'd2, 4'd0, 8'd1);
    bus.pll_locked_i = 1'b0;
    tick(1);
    bus.pll_locked_i = 1'b1;
    tick(2);
    check_outs("glitch_to_wait", 0, 1, 0, 0, 3'd1, 4'd0, 8'd1);
    tick(8);
    check_outs("glitch_edge9", 0, 1, 0, 0, 3'd2, 4'd0, 8'd1);
    tick(1);
    check_outs("glitch_release", 0, 0, 1, 0, 3'd3, 4'd0, 8'd1);

    // Lock never arrives: two timeouts, then FAULT.
    bus.pll_locked_i = 1'b0;
    bus.req_reset_i  = 1'b1;
    tick(1);
    bus.req_reset_i  = 1'b0;
    check_outs("to_start", 1, 1, 0, 0, 3'd0, 4'd0, 8'd1);
    tick(35);
    check_outs("to1_pre", 0, 1, 0, 0, 3'd1, 4'd0, 8'd1);
    tick(1);
    check_outs("to1", 1, 1, 0, 0, 3'd0, 4'd1, 8'd1);
    tick(35);
    check_outs("to2_pre", 0, 1, 0, 0, 3'd1, 4'd1, 8'd1);
    tick(1);
    check_outs("to2_fault", 1, 1, 0, 1, 3'd4, 4'd2, 8'd1);
    tick(50);
    check_outs("fault_hold", 1, 1, 0, 1, 3'd4, 4'd2, 8'd1);

    // Recovery from FAULT with lock present.
    bus.pll_locked_i = 1'b1;
    bus.req_reset_i  = 1'b1;
    tick(1);
    bus.req_reset_i  = 1'b0;
    check_outs("recover", 1, 1, 0, 0, 3'd0, 4'd0, 8'd1);
    tick(12);
    check_outs("recover_stable", 0, 1, 0, 0, 3'd2, 4'd0, 8'd1);
    tick(1);
    check_outs("recover_run", 0, 0, 1, 0, 3'd3, 4'd0, 8'd1);

    // Asynchronous reset between edges.
    tick(3);
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 1, 1, 0, 0, 3'd0, 4'd0, 8'd0);
    tick(2);
    check_outs("async_hold", 1, 1, 0, 0, 3'd0, 4'd0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
